// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg
// Shared definitions for the instruction-memory fetch controller: FSM state
// encoding, next-PC source selector encoding, the default memory depth and a
// helper that decides whether a candidate PC can legally be fetched.

package imem_ctrl_pkg;

    // log2 of the instruction-memory word count used when nobody overrides it
    localparam int DEPTH_DEFAULT = 8;

    // Controller states; the encoding is visible on the state output port
    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_IDLE = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } fetch_state_e;

    // Next-PC source selector; the reserved code behaves like PCSRC_SEQ
    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_RSV = 2'b11
    } pc_src_e;

    // Size of one instruction word in bytes
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // A PC is unusable when it is not word aligned or points past the last word
    function automatic logic pcFaults(input logic [31:0] addr, input int depth);
        logic misaligned;
        logic outOfRange;
        misaligned = (addr[1:0] != 2'b00);
        outOfRange = ((addr >> 2) >= (32'd1 << depth));
        return misaligned || outOfRange;
    endfunction

endpackage

// File: rtl/imem_pc_next.sv
// imem_pc_next
// Purely combinational next-PC selection for the fetch controller. Picks the
// sequential, branch or jump target according to the selector and flags the
// candidate as faulting when it is misaligned or beyond the memory.

module imem_pc_next
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_pc_src,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jump_target,
    output logic [31:0] o_next_pc,
    output logic        o_fault
);

    logic [31:0] w_seq_pc;
    logic [31:0] w_next_pc;

    assign w_seq_pc = i_pc + INSTR_BYTES;

    // Choose the candidate PC; anything that is not branch or jump falls through to PC+4
    always_comb begin
        w_next_pc = w_seq_pc;
        case (i_pc_src)
            PCSRC_BR:  w_next_pc = i_branch_target;
            PCSRC_J:   w_next_pc = i_jump_target;
            default:   w_next_pc = w_seq_pc;
        endcase
    end

    assign o_next_pc = w_next_pc;
    assign o_fault   = pcFaults(w_next_pc, DEPTH);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-memory fetch controller. After reset it streams a program into
// the instruction memory (LOAD), waits for a start pulse (IDLE), then fetches
// one instruction per unstalled cycle with zero latency (RUN) until a bad
// next PC sends it to HALT, where it stays until reset.
// Optional feature: define IMEM_FETCH_PERF_EN to add the retired_cnt output,
// a wrapping count of RUN cycles that presented a valid instruction.

module imem_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        start,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rd,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [1:0]  state,
    output logic        fault
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    fetch_state_e     r_state;
    logic [DEPTH-1:0] r_ld_ptr;
    logic [31:0]      r_pc;
    logic             r_fault;

    logic [31:0]      w_next_pc;
    logic             w_next_fault;
    logic             w_ptr_full;
    logic             w_fetch_valid;
    logic [31:0]      w_load_addr;

    // Next-PC candidate and its legality come from the combinational helper
    imem_pc_next #(
        .DEPTH (DEPTH)
    ) u_pc_next (
        .i_pc            (r_pc),
        .i_pc_src        (pc_src),
        .i_branch_target (branch_target),
        .i_jump_target   (jump_target),
        .o_next_pc       (w_next_pc),
        .o_fault         (w_next_fault)
    );

    // The last word slot ends the load even without ld_last, so the pointer never wraps over the program
    assign w_ptr_full    = &r_ld_ptr;
    assign w_fetch_valid = (r_state == ST_RUN) && !stall && !reset;
    assign w_load_addr   = 32'({r_ld_ptr, 2'b00});

    // Main controller: state, load pointer, program counter and sticky fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_LOAD;
            r_ld_ptr <= '0;
            r_pc     <= '0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (ld_valid) begin
                        r_ld_ptr <= r_ld_ptr + DEPTH'(1);
                        if (ld_last || w_ptr_full) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_pc    <= '0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (w_next_fault) begin
                            r_state <= ST_HALT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] r_retired_cnt;

    // Count delivered instructions for the current run; a fresh start restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_cnt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_retired_cnt <= '0;
        end else if (w_fetch_valid) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`endif

    // Decode the memory-side and fetch-side outputs from the current state; reset masks all handshakes
    always_comb begin
        ld_ready    = 1'b0;
        imem_we     = 1'b0;
        imem_addr   = '0;
        imem_wdata  = '0;
        instr       = '0;
        instr_valid = 1'b0;
        case (r_state)
            ST_LOAD: begin
                ld_ready   = !reset;
                imem_we    = ld_valid && !reset;
                imem_addr  = w_load_addr;
                imem_wdata = ld_data;
            end
            ST_RUN: begin
                imem_addr   = r_pc;
                instr       = imem_rd;
                instr_valid = w_fetch_valid;
            end
            default: begin
                imem_addr = '0;
            end
        endcase
    end

    assign pc    = r_pc;
    assign state = r_state;
    assign fault = r_fault;

endmodule
